// File: rtl/mem_stage_lsu_pkg.sv
// Shared CPU encodings used by the memory stage: load types and the
// load-response FSM states.
package mem_stage_lsu_pkg;

  typedef enum logic [2:0] {
    LD_B  = 3'd0,
    LD_BU = 3'd1,
    LD_H  = 3'd2,
    LD_HU = 3'd3,
    LD_W  = 3'd4,
    LD_WU = 3'd5,
    LD_D  = 3'd6
  } ld_type_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RSP = 2'd1,
    ST_HAVE_RSP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_load_align_ext.sv
// Picks the addressed byte/half/word lane out of a raw aligned data word
// (little-endian) and sign- or zero-extends it to the full data width.
module load_align_ext
  import mem_stage_lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OFFS_W = $clog2(DATA_W / 8)
) (
  input  logic [2:0]        ld_type,
  input  logic [OFFS_W-1:0] addr_lo,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] data
);

  logic [OFFS_W-1:0] lane_mask;
  logic [OFFS_W-1:0] lane_off;
  logic [DATA_W-1:0] lane;

  always_comb begin
    // Misaligned offsets fall back to the naturally aligned lane below them.
    case (ld_type)
      LD_B, LD_BU: lane_mask = '1;
      LD_H, LD_HU: lane_mask = ~OFFS_W'(1);
      LD_W, LD_WU: lane_mask = ~OFFS_W'(3);
      default:     lane_mask = '0;
    endcase
    lane_off = addr_lo & lane_mask;
    lane     = raw >> {lane_off, 3'b000};

    // On a 32-bit path WU and D collapse to the whole word, same as W.
    case (ld_type)
      LD_B:    data = DATA_W'(signed'(lane[7:0]));
      LD_BU:   data = DATA_W'(lane[7:0]);
      LD_H:    data = DATA_W'(signed'(lane[15:0]));
      LD_HU:   data = DATA_W'(lane[15:0]);
      LD_W:    data = DATA_W'(signed'(lane[31:0]));
      LD_WU:   data = DATA_W'(lane[31:0]);
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: holds one instruction, waits for at most one data-RAM
// load response, aligns/extends the load data and hands the result to WB.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int RF_AW  = 5,
  parameter  int PC_W   = 32,
  localparam int OFFS_W = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              mem_allow_in,
  input  logic              ex_is_load,
  input  logic              ex_rf_we,
  input  logic [2:0]        ex_ld_type,
  input  logic [OFFS_W-1:0] ex_addr_lo,
  input  logic [RF_AW-1:0]  ex_rf_waddr,
  input  logic [DATA_W-1:0] ex_rf_wdata,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata,
  input  logic              wb_allow_in,
  output logic              mem_to_wb_valid,
  output logic              wb_rf_we,
  output logic [RF_AW-1:0]  wb_rf_waddr,
  output logic [DATA_W-1:0] wb_rf_wdata,
  output logic [PC_W-1:0]   wb_pc,
  output logic              by_valid,
  output logic              by_rf_we,
  output logic [RF_AW-1:0]  by_waddr,
  output logic [DATA_W-1:0] by_wdata,
  output logic              by_pending,
  output logic              rsp_err
);

  lsu_state_e        state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic              is_load_q, is_load_d;
  logic              rf_we_q, rf_we_d;
  logic [2:0]        ld_type_q, ld_type_d;
  logic [OFFS_W-1:0] addr_lo_q, addr_lo_d;
  logic [RF_AW-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              rsp_err_q, rsp_err_d;

  logic              ready_go;
  logic              use_hold;
  logic              capture_rsp;
  logic              stray_rsp;
  logic              latch;
  logic              new_load;
  logic              wb_xfer;
  logic [DATA_W-1:0] ld_raw;
  logic [DATA_W-1:0] ld_ext;

  assign mem_allow_in    = !mem_valid_q || (ready_go && wb_allow_in);
  assign mem_to_wb_valid = mem_valid_q && ready_go;
  assign latch           = ex_valid && mem_allow_in;
  assign new_load        = latch && ex_is_load;
  assign wb_xfer         = mem_to_wb_valid && wb_allow_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (new_load) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (wb_xfer)      state_d = new_load ? ST_WAIT_RSP : ST_IDLE;
        else if (data_ok) state_d = ST_HAVE_RSP;
      end
      ST_HAVE_RSP: begin
        if (wb_xfer) state_d = new_load ? ST_WAIT_RSP : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_go    = !is_load_q || (state_q == ST_HAVE_RSP) ||
                  ((state_q == ST_WAIT_RSP) && data_ok);
    use_hold    = (state_q == ST_HAVE_RSP);
    capture_rsp = (state_q == ST_WAIT_RSP) && data_ok && !wb_allow_in;
    stray_rsp   = data_ok && (state_q != ST_WAIT_RSP);
  end

  always_comb begin
    mem_valid_d = mem_valid_q;
    is_load_d   = is_load_q;
    rf_we_d     = rf_we_q;
    ld_type_d   = ld_type_q;
    addr_lo_d   = addr_lo_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    rsp_err_d   = rsp_err_q || stray_rsp;
    if (latch) begin
      mem_valid_d = 1'b1;
      is_load_d   = ex_is_load;
      rf_we_d     = ex_rf_we;
      ld_type_d   = ex_ld_type;
      addr_lo_d   = ex_addr_lo;
      waddr_d     = ex_rf_waddr;
      wdata_d     = ex_rf_wdata;
      pc_d        = ex_pc;
    end else if (mem_allow_in) begin
      mem_valid_d = 1'b0;
    end
    if (capture_rsp) hold_d = rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_valid_q <= 1'b0;
      is_load_q   <= 1'b0;
      rf_we_q     <= 1'b0;
      ld_type_q   <= 3'd0;
      addr_lo_q   <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      pc_q        <= '0;
      hold_q      <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      mem_valid_q <= mem_valid_d;
      is_load_q   <= is_load_d;
      rf_we_q     <= rf_we_d;
      ld_type_q   <= ld_type_d;
      addr_lo_q   <= addr_lo_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      pc_q        <= pc_d;
      hold_q      <= hold_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // A response that arrives while WB is ready flows straight through.
  assign ld_raw = use_hold ? hold_q : rdata;

  load_align_ext #(
    .DATA_W(DATA_W)
  ) u_align (
    .ld_type(ld_type_q),
    .addr_lo(addr_lo_q),
    .raw    (ld_raw),
    .data   (ld_ext)
  );

  assign wb_rf_we    = rf_we_q;
  assign wb_rf_waddr = waddr_q;
  assign wb_rf_wdata = is_load_q ? ld_ext : wdata_q;
  assign wb_pc       = pc_q;

  assign by_valid    = mem_valid_q;
  assign by_rf_we    = rf_we_q;
  assign by_waddr    = waddr_q;
  assign by_wdata    = wb_rf_wdata;
  assign by_pending  = mem_valid_q && is_load_q && !ready_go;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed-vector bench for mem_stage_lsu: a 32-bit instance driven from a
// per-cycle table, plus hand sequences for reset-mid-load and the 64-bit path.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        ex_valid, ex_is_load, ex_rf_we, data_ok, wb_allow_in;
  logic [2:0]  ex_ld_type;
  logic [1:0]  ex_addr_lo;
  logic [4:0]  ex_rf_waddr;
  logic [31:0] ex_rf_wdata, ex_pc, rdata;
  logic        mem_allow_in, mem_to_wb_valid, wb_rf_we, by_valid, by_rf_we, by_pending, rsp_err;
  logic [4:0]  wb_rf_waddr, by_waddr;
  logic [31:0] wb_rf_wdata, wb_pc, by_wdata;

  logic        d_ex_valid, d_ex_is_load, d_ex_rf_we, d_data_ok, d_wb_allow_in;
  logic [2:0]  d_ex_ld_type;
  logic [2:0]  d_ex_addr_lo;
  logic [4:0]  d_ex_rf_waddr;
  logic [63:0] d_ex_rf_wdata, d_rdata;
  logic [31:0] d_ex_pc;
  logic        d_mem_allow_in, d_mem_to_wb_valid, d_wb_rf_we, d_by_valid, d_by_rf_we, d_by_pending, d_rsp_err;
  logic [4:0]  d_wb_rf_waddr, d_by_waddr;
  logic [63:0] d_wb_rf_wdata, d_by_wdata;
  logic [31:0] d_wb_pc;

  mem_stage_lsu #(.DATA_W(32), .RF_AW(5), .PC_W(32)) u32 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .mem_allow_in(mem_allow_in),
    .ex_is_load(ex_is_load), .ex_rf_we(ex_rf_we), .ex_ld_type(ex_ld_type),
    .ex_addr_lo(ex_addr_lo), .ex_rf_waddr(ex_rf_waddr), .ex_rf_wdata(ex_rf_wdata),
    .ex_pc(ex_pc), .data_ok(data_ok), .rdata(rdata), .wb_allow_in(wb_allow_in),
    .mem_to_wb_valid(mem_to_wb_valid), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr),
    .wb_rf_wdata(wb_rf_wdata), .wb_pc(wb_pc), .by_valid(by_valid), .by_rf_we(by_rf_we),
    .by_waddr(by_waddr), .by_wdata(by_wdata), .by_pending(by_pending), .rsp_err(rsp_err)
  );

  mem_stage_lsu #(.DATA_W(64), .RF_AW(5), .PC_W(32)) u64 (
    .clk(clk), .reset(reset), .ex_valid(d_ex_valid), .mem_allow_in(d_mem_allow_in),
    .ex_is_load(d_ex_is_load), .ex_rf_we(d_ex_rf_we), .ex_ld_type(d_ex_ld_type),
    .ex_addr_lo(d_ex_addr_lo), .ex_rf_waddr(d_ex_rf_waddr), .ex_rf_wdata(d_ex_rf_wdata),
    .ex_pc(d_ex_pc), .data_ok(d_data_ok), .rdata(d_rdata), .wb_allow_in(d_wb_allow_in),
    .mem_to_wb_valid(d_mem_to_wb_valid), .wb_rf_we(d_wb_rf_we), .wb_rf_waddr(d_wb_rf_waddr),
    .wb_rf_wdata(d_wb_rf_wdata), .wb_pc(d_wb_pc), .by_valid(d_by_valid), .by_rf_we(d_by_rf_we),
    .by_waddr(d_by_waddr), .by_wdata(d_by_wdata), .by_pending(d_by_pending), .rsp_err(d_rsp_err)
  );

  typedef struct {
    logic        v, ld;
    logic [2:0]  lt;
    logic [1:0]  al;
    logic [31:0] wd;
    logic        dok;
    logic [31:0] rd;
    logic        wba;
    logic        e_ain, e_ov, e_byv, e_pend, e_err;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input logic v, input logic ld, input logic [2:0] lt, input logic [1:0] al,
                     input logic [31:0] wd, input logic dok, input logic [31:0] rd, input logic wba,
                     input logic e_ain, input logic e_ov, input logic e_byv, input logic e_pend,
                     input logic e_err, input logic [31:0] e_wd);
    vec_t t;
    t.v = v; t.ld = ld; t.lt = lt; t.al = al; t.wd = wd; t.dok = dok; t.rd = rd; t.wba = wba;
    t.e_ain = e_ain; t.e_ov = e_ov; t.e_byv = e_byv; t.e_pend = e_pend; t.e_err = e_err;
    t.e_wd = e_wd;
    vq.push_back(t);
  endtask

  task automatic idle(input logic e_err);
    add(0, 0, 3'd0, 2'd0, 32'h0, 0, 32'h0, 1, 1, 0, 0, 0, e_err, 32'h0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    ex_valid = 0; ex_is_load = 0; ex_rf_we = 0; ex_ld_type = 0; ex_addr_lo = 0;
    ex_rf_waddr = 0; ex_rf_wdata = 0; ex_pc = 0; data_ok = 0; rdata = 0; wb_allow_in = 1;
    d_ex_valid = 0; d_ex_is_load = 0; d_ex_rf_we = 0; d_ex_ld_type = 0; d_ex_addr_lo = 0;
    d_ex_rf_waddr = 0; d_ex_rf_wdata = 0; d_ex_pc = 0; d_data_ok = 0; d_rdata = 0;
    d_wb_allow_in = 1;

    // ALU op: one cycle in MEM
    add(1, 0, 3'd0, 2'd0, 32'h1234_5678, 0, 32'h0, 1, 1, 0, 0, 0, 0, 32'h0);
    add(0, 0, 3'd0, 2'd0, 32'h0, 0, 32'h0, 1, 1, 1, 1, 0, 0, 32'h1234_5678);
    idle(0);
    // LB offset 3, response after three pending cycles
    add(1, 1, LD_B, 2'd3, 32'h0, 0, 32'h0, 1, 1, 0, 0, 0, 0, 32'h0);
    for (int k = 0; k < 3; k++) add(0, 0, 3'd0, 2'd0, 32'h0, 0, 32'h0, 1, 0, 0, 1, 1, 0, 32'h0);
    add(0, 0, 3'd0, 2'd0, 32'h0, 1, 32'h80FF_0000, 1, 1, 1, 1, 0, 0, 32'hFFFF_FF80);
    idle(0);
    // LHU offset 2, response while WB stalls, held two cycles
    add(1, 1, LD_HU, 2'd2, 32'h0, 0, 32'h0, 1, 1, 0, 0, 0, 0, 32'h0);
    add(0, 0, 3'd0, 2'd0, 32'h0, 1, 32'hBEEF_0000, 0, 0, 1, 1, 0, 0, 32'h0000_BEEF);
    add(0, 0, 3'd0, 2'd0, 32'h0, 0, 32'h0, 0, 0, 1, 1, 0, 0, 32'h0000_BEEF);
    add(0, 0, 3'd0, 2'd0, 32'h0, 0, 32'h0, 0, 0, 1, 1, 0, 0, 32'h0000_BEEF);
    add(0, 0, 3'd0, 2'd0, 32'h0, 0, 32'h0, 1, 1, 1, 1, 0, 0, 32'h0000_BEEF);
    idle(0);
    // back-to-back loads, one retire per cycle; LH at offset 3 uses lane 2
    add(1, 1, LD_W, 2'd0, 32'h0, 0, 32'h0, 1, 1, 0, 0, 0, 0, 32'h0);
    add(1, 1, LD_B, 2'd1, 32'h0, 1, 32'h1122_3344, 1, 1, 1, 1, 0, 0, 32'h1122_3344);
    add(1, 1, LD_H, 2'd3, 32'h0, 1, 32'h1234_7F00, 1, 1, 1, 1, 0, 0, 32'h0000_007F);
    add(0, 0, 3'd0, 2'd0, 32'h0, 1, 32'h9ABC_0000, 1, 1, 1, 1, 0, 0, 32'hFFFF_9ABC);
    idle(0);
    // D and WU on a 32-bit path act as W; BU zero-extends
    add(1, 1, LD_D, 2'd1, 32'h0, 0, 32'h0, 1, 1, 0, 0, 0, 0, 32'h0);
    add(1, 1, LD_BU, 2'd2, 32'h0, 1, 32'h8765_4321, 1, 1, 1, 1, 0, 0, 32'h8765_4321);
    add(1, 1, LD_WU, 2'd2, 32'h0, 1, 32'h00F0_0000, 1, 1, 1, 1, 0, 0, 32'h0000_00F0);
    add(0, 0, 3'd0, 2'd0, 32'h0, 1, 32'hF000_0001, 1, 1, 1, 1, 0, 0, 32'hF000_0001);
    idle(0);
    // ALU op stalled by WB, then a second ALU op accepted on the retire edge
    add(1, 0, 3'd0, 2'd0, 32'hCAFE_F00D, 0, 32'h0, 0, 1, 0, 0, 0, 0, 32'h0);
    add(1, 0, 3'd0, 2'd0, 32'h0BAD_BEEF, 0, 32'h0, 0, 0, 1, 1, 0, 0, 32'hCAFE_F00D);
    add(1, 0, 3'd0, 2'd0, 32'h0BAD_BEEF, 0, 32'h0, 1, 1, 1, 1, 0, 0, 32'hCAFE_F00D);
    add(0, 0, 3'd0, 2'd0, 32'h0, 0, 32'h0, 1, 1, 1, 1, 0, 0, 32'h0BAD_BEEF);
    idle(0);
    // stray response in IDLE sets the sticky error
    add(0, 0, 3'd0, 2'd0, 32'h0, 1, 32'h0000_DEAD, 1, 1, 0, 0, 0, 0, 32'h0);
    idle(1);
    idle(1);

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_allow_in", mem_allow_in, 1);
    chk("rst_to_wb_valid", mem_to_wb_valid, 0);
    chk("rst_by_valid", by_valid, 0);
    chk("rst_by_pending", by_pending, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_wb_wdata", wb_rf_wdata, 0);
    chk("rst_wb_pc", wb_pc, 0);
    chk("rst64_allow_in", d_mem_allow_in, 1);
    chk("rst64_wb_wdata", d_wb_rf_wdata, 0);
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      ex_valid = vq[i].v; ex_is_load = vq[i].ld; ex_rf_we = vq[i].v; ex_ld_type = vq[i].lt;
      ex_addr_lo = vq[i].al; ex_rf_wdata = vq[i].wd; data_ok = vq[i].dok; rdata = vq[i].rd;
      wb_allow_in = vq[i].wba; ex_rf_waddr = 5'(i); ex_pc = 32'h1000 + 32'(i * 4);
      @(negedge clk);
      chk($sformatf("v%0d allow_in", i), mem_allow_in, vq[i].e_ain);
      chk($sformatf("v%0d to_wb_valid", i), mem_to_wb_valid, vq[i].e_ov);
      chk($sformatf("v%0d by_valid", i), by_valid, vq[i].e_byv);
      chk($sformatf("v%0d by_pending", i), by_pending, vq[i].e_pend);
      chk($sformatf("v%0d rsp_err", i), rsp_err, vq[i].e_err);
      if (vq[i].e_ov) begin
        chk($sformatf("v%0d wb_wdata", i), wb_rf_wdata, vq[i].e_wd);
        chk($sformatf("v%0d by_wdata", i), by_wdata, vq[i].e_wd);
      end
      $display("vec %0d: allow_in=%0b to_wb=%0b pend=%0b err=%0b wdata=%08h",
               i, mem_allow_in, mem_to_wb_valid, by_pending, rsp_err, wb_rf_wdata);
    end

    // reset while a load waits, then a late response
    @(posedge clk); #1;
    ex_valid = 1; ex_is_load = 1; ex_ld_type = LD_W; ex_addr_lo = 0; data_ok = 0; wb_allow_in = 1;
    @(posedge clk); #1;
    ex_valid = 0; ex_is_load = 0;
    @(negedge clk);
    chk("midrst_pending_before", by_pending, 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_async_pending", by_pending, 0);
    chk("midrst_async_by_valid", by_valid, 0);
    chk("midrst_async_to_wb", mem_to_wb_valid, 0);
    chk("midrst_async_allow_in", mem_allow_in, 1);
    chk("midrst_async_rsp_err", rsp_err, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    data_ok = 1; rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("late_rsp_to_wb", mem_to_wb_valid, 0);
    chk("late_rsp_by_valid", by_valid, 0);
    @(posedge clk); #1;
    data_ok = 0;
    @(negedge clk);
    chk("late_rsp_err", rsp_err, 1);
    $display("reset-mid-load: to_wb=%0b err=%0b", mem_to_wb_valid, rsp_err);

    // 64-bit path: D, WU at offset 4, W at offset 5 (masked to 4)
    @(posedge clk); #1;
    d_ex_valid = 1; d_ex_is_load = 1; d_ex_ld_type = LD_D; d_ex_addr_lo = 3'd0;
    @(posedge clk); #1;
    d_ex_ld_type = LD_WU; d_ex_addr_lo = 3'd4; d_data_ok = 1; d_rdata = 64'h8000_0000_0000_0001;
    @(negedge clk);
    chk("d64_to_wb", d_mem_to_wb_valid, 1);
    chk("d64_wdata", d_wb_rf_wdata, 64'h8000_0000_0000_0001);
    $display("d64 D: wdata=%016h", d_wb_rf_wdata);
    @(posedge clk); #1;
    d_ex_ld_type = LD_W; d_ex_addr_lo = 3'd5; d_rdata = 64'h8000_0000_1234_5678;
    @(negedge clk);
    chk("wu64_wdata", d_wb_rf_wdata, 64'h0000_0000_8000_0000);
    $display("d64 WU: wdata=%016h", d_wb_rf_wdata);
    @(posedge clk); #1;
    d_ex_valid = 0; d_ex_is_load = 0;
    @(negedge clk);
    chk("w64_wdata", d_wb_rf_wdata, 64'hFFFF_FFFF_8000_0000);
    $display("d64 W: wdata=%016h", d_wb_rf_wdata);
    @(posedge clk); #1;
    d_data_ok = 0;
    @(negedge clk);
    chk("d64_idle_to_wb", d_mem_to_wb_valid, 0);
    chk("d64_rsp_err", d_rsp_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
